// File: rtl/circulant_transpose_pingpong.sv
// circulant_transpose_pingpong: ping-pong matrix transpose buffer with circulant lane storage
module circulant_transpose_pingpong #(
  parameter int MATRIX_DIM = 4,
  parameter int COL_WIDTH  = 8,
  parameter int WORD_LEN   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic                in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_last,
  output logic [1:0]          bank_full
);
  localparam int ELEMS    = WORD_LEN / COL_WIDTH;
  localparam int ADDR_LEN = $clog2(MATRIX_DIM);
  localparam int WPR      = MATRIX_DIM / ELEMS;
  localparam logic [ADDR_LEN-1:0] LAST_IDX  = ADDR_LEN'(MATRIX_DIM - 1);
  localparam logic [ADDR_LEN-1:0] LAST_WORD = ADDR_LEN'(WPR - 1);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} st_t;

  st_t st_q [2];
  st_t st_d [2];
  logic [COL_WIDTH-1:0] mem [2][MATRIX_DIM][MATRIX_DIM];
  logic [ADDR_LEN-1:0] wr_lane [ELEMS];
  logic [ADDR_LEN-1:0] wr_row, wr_word, rd_a, rd_b;
  logic [WORD_LEN-1:0] rd_word, s1_data;
  logic [1:0] mode_q;
  logic wr_bank, rd_bank, rd_busy, s1_valid, s1_last, s1_bank, out_bank;
  logic wr_fire, wr_end, out_en, rd_ok, issue, rd_end, last_fire;

  assign wr_fire   = in_valid && in_ready;
  assign wr_end    = wr_row == LAST_IDX && wr_word == LAST_WORD;
  assign out_en    = !out_valid || out_ready;
  assign issue     = rd_ok && out_en;
  assign rd_end    = rd_a == LAST_IDX && rd_b == LAST_WORD;
  assign last_fire = out_valid && out_ready && out_last;

  // element (r,c) lives in lane r+c, entry r; a row or column slice never repeats a lane
  for (genvar k = 0; k < ELEMS; k++) begin : g_el
    logic [ADDR_LEN-1:0] ri, rr, rc, rl;
    assign wr_lane[k] = wr_row + ADDR_LEN'(wr_word * ELEMS + k);
    assign ri = ADDR_LEN'(rd_b * ELEMS + k);
    assign rr = mode_q[rd_bank] ? ri : rd_a;
    assign rc = mode_q[rd_bank] ? rd_a : ri;
    assign rl = rr + rc;
    assign rd_word[k*COL_WIDTH +: COL_WIDTH] = mem[rd_bank][rl][rr];
  end

  always_ff @(posedge clk)
    if (wr_fire && !clear)
      for (int k = 0; k < ELEMS; k++)
        mem[wr_bank][wr_lane[k]][wr_row] <= in_data[k*COL_WIDTH +: COL_WIDTH];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st_q <= '{default: EMPTY};
    else st_q <= st_d;

  always_comb
    for (int b = 0; b < 2; b++) begin
      st_d[b] = st_q[b];
      if (clear) st_d[b] = EMPTY;
      else if (wr_fire && wr_bank == 1'(b)) st_d[b] = wr_end ? FULL : FILLING;
      else if (issue && rd_bank == 1'(b) && st_q[b] == FULL) st_d[b] = DRAINING;
      else if (last_fire && out_bank == 1'(b)) st_d[b] = EMPTY;
    end

  always_comb begin
    in_ready  = rst_n && (st_q[wr_bank] == EMPTY || st_q[wr_bank] == FILLING);
    rd_ok     = st_q[rd_bank] == FULL || rd_busy;
    bank_full = {st_q[1] == FULL || st_q[1] == DRAINING, st_q[0] == FULL || st_q[0] == DRAINING};
  end

  // two-stage read pipe (memory read, output register) advancing as one on out_en
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {wr_bank, rd_bank, rd_busy, s1_valid, s1_last, s1_bank, out_valid, out_last, out_bank} <= '0;
      {wr_row, wr_word, rd_a, rd_b} <= '0;
      mode_q   <= '0;
      s1_data  <= '0;
      out_data <= '0;
    end else if (clear) begin
      {wr_bank, rd_bank, rd_busy, s1_valid, s1_last, s1_bank, out_valid, out_last, out_bank} <= '0;
      {wr_row, wr_word, rd_a, rd_b} <= '0;
    end else begin
      if (wr_fire) begin
        if (st_q[wr_bank] == EMPTY) mode_q[wr_bank] <= in_mode;
        wr_word <= wr_word == LAST_WORD ? '0 : wr_word + 1'b1;
        if (wr_word == LAST_WORD) wr_row <= wr_row + 1'b1;
        wr_bank <= wr_bank ^ wr_end;
      end
      if (out_en) begin
        s1_valid  <= issue;
        s1_last   <= issue && rd_end;
        out_valid <= s1_valid;
        out_last  <= s1_last;
        if (issue) begin
          s1_data <= rd_word;
          s1_bank <= rd_bank;
        end
        if (s1_valid) begin
          out_data <= s1_data;
          out_bank <= s1_bank;
        end
      end
      if (issue) begin
        rd_b    <= rd_b == LAST_WORD ? '0 : rd_b + 1'b1;
        if (rd_b == LAST_WORD) rd_a <= rd_a + 1'b1;
        rd_busy <= !rd_end;
        rd_bank <= rd_bank ^ rd_end;
      end
    end
endmodule

// File: tb/tb_circulant_transpose_pingpong.sv
// tb_circulant_transpose_pingpong: directed and scoreboard tests for the ping-pong transpose buffer
module tb_circulant_transpose_pingpong;
  logic clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [15:0] out_data;
  logic [1:0] bank_full;

  circulant_transpose_pingpong #(.MATRIX_DIM(4), .COL_WIDTH(8), .WORD_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  int wi, cyc, last_in_cyc, ready_bad;
  logic [15:0] in_words[$];
  logic in_modes[$];
  logic [15:0] got_data[$];
  logic got_last[$];
  int got_cyc[$];
  logic [15:0] mat_in [8] = '{16'h0100, 16'h0302, 16'h1110, 16'h1312, 16'h2120, 16'h2322, 16'h3130, 16'h3332};
  logic [15:0] trn [8]    = '{16'h1000, 16'h3020, 16'h1101, 16'h3121, 16'h1202, 16'h3222, 16'h1303, 16'h3323};

  task automatic reset_drv();
    in_words.delete(); in_modes.delete(); got_data.delete(); got_last.delete(); got_cyc.delete();
    wi = 0; cyc = 0; last_in_cyc = -1; ready_bad = 0;
  endtask

  task automatic load(input logic [15:0] w [8], input logic m);
    for (int i = 0; i < 8; i++) begin
      in_words.push_back(w[i]);
      in_modes.push_back(i == 0 ? m : !m);
    end
  endtask

  task automatic run_stream(input int in_pct, input int out_pct, input int n_out, input int max_cyc);
    int n = 0;
    while (got_data.size() < n_out && n < max_cyc) begin
      in_valid  = wi < int'(in_words.size()) && $urandom_range(99) < in_pct;
      in_data   = wi < int'(in_words.size()) ? in_words[wi] : '0;
      in_mode   = wi < int'(in_words.size()) ? in_modes[wi] : 1'b0;
      out_ready = $urandom_range(99) < out_pct;
      #1;
      if (in_valid && in_ready) begin wi++; last_in_cyc = cyc; end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data); got_last.push_back(out_last); got_cyc.push_back(cyc);
      end
      if (in_ready !== !(&bank_full)) ready_bad++;
      @(posedge clk); #1;
      cyc++; n++;
    end
    in_valid = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (bank_full !== 2'b00) begin fails++; $display("FAIL reset_bank_full: got %b expected 00", bank_full); end
    rst_n = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_transpose();
    reset_drv(); load(mat_in, 1'b1);
    run_stream(100, 100, 8, 100);
    checks++; if (got_data.size() != 8) begin fails++; $display("FAIL t1_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== trn[i]) begin fails++; $display("FAIL t1_data[%0d]: got %h expected %h", i, got_data[i], trn[i]); end
      checks++; if (got_last[i] !== (i == 7)) begin fails++; $display("FAIL t1_last[%0d]: got %b expected %b", i, got_last[i], i == 7); end
    end
    if (got_data.size() == 8) begin
      checks++; if (got_cyc[0] != last_in_cyc + 3) begin fails++; $display("FAIL t1_latency: got cycle %0d expected %0d", got_cyc[0], last_in_cyc + 3); end
      checks++; if (got_cyc[7] - got_cyc[0] != 7) begin fails++; $display("FAIL t1_gaps: got span %0d expected 7", got_cyc[7] - got_cyc[0]); end
    end
  endtask

  task automatic test_passthrough();
    reset_drv(); load(mat_in, 1'b0);
    run_stream(100, 100, 8, 100);
    checks++; if (got_data.size() != 8) begin fails++; $display("FAIL t2_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== mat_in[i]) begin fails++; $display("FAIL t2_data[%0d]: got %h expected %h", i, got_data[i], mat_in[i]); end
      checks++; if (got_last[i] !== (i == 7)) begin fails++; $display("FAIL t2_last[%0d]: got %b expected %b", i, got_last[i], i == 7); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    reset_drv(); load(mat_in, 1'b1); load(mat_in, 1'b0); load(mat_in, 1'b1);
    run_stream(100, 100, 24, 200);
    checks++; if (got_data.size() != 24) begin fails++; $display("FAIL t3_count: got %0d expected 24", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = (i / 8 == 1) ? mat_in[i % 8] : trn[i % 8];
      checks++; if (got_data[i] !== e) begin fails++; $display("FAIL t3_data[%0d]: got %h expected %h", i, got_data[i], e); end
      checks++; if (got_last[i] !== (i % 8 == 7)) begin fails++; $display("FAIL t3_last[%0d]: got %b expected %b", i, got_last[i], i % 8 == 7); end
    end
    if (got_data.size() == 24) begin
      checks++; if (got_cyc[15] - got_cyc[0] != 15) begin fails++; $display("FAIL t3_gaps_first_two: got span %0d expected 15", got_cyc[15] - got_cyc[0]); end
      checks++; if (got_cyc[23] - got_cyc[16] != 7) begin fails++; $display("FAIL t3_gaps_third: got span %0d expected 7", got_cyc[23] - got_cyc[16]); end
    end
    checks++; if (ready_bad != 0) begin fails++; $display("FAIL t3_in_ready: got %0d bad cycles expected 0", ready_bad); end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    reset_drv(); load(mat_in, 1'b1); load(mat_in, 1'b0);
    run_stream(100, 100, 1, 50);
    run_stream(100, 0, 1000, 30);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t4_hold_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'h3020) begin fails++; $display("FAIL t4_hold_data: got %h expected 3020", out_data); end
    checks++; if (out_last !== 1'b0) begin fails++; $display("FAIL t4_hold_last: got %b expected 0", out_last); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t4_in_ready: got %b expected 0", in_ready); end
    checks++; if (bank_full !== 2'b11) begin fails++; $display("FAIL t4_bank_full: got %b expected 11", bank_full); end
    checks++; if (wi != 16) begin fails++; $display("FAIL t4_words_taken: got %0d expected 16", wi); end
    run_stream(100, 100, 16, 100);
    checks++; if (got_data.size() != 16) begin fails++; $display("FAIL t4_count: got %0d expected 16", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      e = i < 8 ? trn[i] : mat_in[i - 8];
      checks++; if (got_data[i] !== e) begin fails++; $display("FAIL t4_data[%0d]: got %h expected %h", i, got_data[i], e); end
    end
    checks++; if (ready_bad != 0) begin fails++; $display("FAIL t4_in_ready_rule: got %0d bad cycles expected 0", ready_bad); end
  endtask

  task automatic test_random();
    logic [7:0] e [4][4];
    logic [15:0] exp_q[$];
    logic m;
    reset_drv();
    for (int mi = 0; mi < 20; mi++) begin
      m = 1'($urandom_range(1));
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) e[r][c] = 8'($urandom);
      for (int r = 0; r < 4; r++)
        for (int w = 0; w < 2; w++) begin
          in_words.push_back({e[r][2*w+1], e[r][2*w]});
          in_modes.push_back(r == 0 && w == 0 ? m : 1'($urandom_range(1)));
        end
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 2; b++)
          exp_q.push_back(m ? {e[2*b+1][a], e[2*b][a]} : {e[a][2*b+1], e[a][2*b]});
    end
    run_stream(50, 50, 160, 20000);
    checks++; if (got_data.size() != 160) begin fails++; $display("FAIL t5_count: got %0d expected 160", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_q[i]) begin fails++; $display("FAIL t5_data[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
      checks++; if (got_last[i] !== (i % 8 == 7)) begin fails++; $display("FAIL t5_last[%0d]: got %b expected %b", i, got_last[i], i % 8 == 7); end
    end
    checks++; if (ready_bad != 0) begin fails++; $display("FAIL t5_in_ready_rule: got %0d bad cycles expected 0", ready_bad); end
  endtask

  task automatic test_reset_clear();
    reset_drv(); load(mat_in, 1'b1);
    run_stream(100, 100, 1000, 5);
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t6_rst_in_ready: got %b expected 0", in_ready); end
    checks++; if (bank_full !== 2'b00) begin fails++; $display("FAIL t6_rst_bank_full: got %b expected 00", bank_full); end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    reset_drv(); load(mat_in, 1'b0);
    run_stream(100, 100, 3, 50);
    checks++; if (got_data.size() != 3) begin fails++; $display("FAIL t6_pre_clear_count: got %0d expected 3", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== mat_in[i]) begin fails++; $display("FAIL t6_pre_clear[%0d]: got %h expected %h", i, got_data[i], mat_in[i]); end
    end
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t6_clr_out_valid: got %b expected 0", out_valid); end
    checks++; if (bank_full !== 2'b00) begin fails++; $display("FAIL t6_clr_bank_full: got %b expected 00", bank_full); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL t6_clr_in_ready: got %b expected 1", in_ready); end
    reset_drv(); load(mat_in, 1'b1);
    run_stream(100, 100, 8, 100);
    checks++; if (got_data.size() != 8) begin fails++; $display("FAIL t6_count: got %0d expected 8", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== trn[i]) begin fails++; $display("FAIL t6_data[%0d]: got %h expected %h", i, got_data[i], trn[i]); end
      checks++; if (got_last[i] !== (i == 7)) begin fails++; $display("FAIL t6_last[%0d]: got %b expected %b", i, got_last[i], i == 7); end
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_passthrough();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
